vm_change_dispenser: RTL and testbench

- Output-side counterpart of the vending machine's change interface.
- The vending FSM hands over a change amount (in cents). This block breaks it into coins using a greedy 25/10/5/1 scheme.
- Drives one coin hopper at a time through an eject/ack handshake, then reports completion and any unpaid remainder.
- Sits between the vending machine core and the physical coin hoppers; it terminates the change request that the vending core originates.

---
 rtl/vm_change_pkg.sv | 36 +++
 rtl/vm_coin_select.sv | 33 +++
 rtl/vm_change_dispenser.sv | 106 ++++++++++
 tb/tb_vm_change_dispenser.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vm_change_pkg.sv
// Shared types and coin constants for the change dispenser.
// Coin codes are one-hot so they drive the hopper eject lines directly.
package vm_change_pkg;

   localparam int COIN_VAL_W = 8;

   typedef enum logic [3:0] {
      COIN_1  = 4'b0001,
      COIN_5  = 4'b0010,
      COIN_10 = 4'b0100,
      COIN_25 = 4'b1000
   } coin_e;

   localparam logic [COIN_VAL_W-1:0] VAL_25 = 8'd25;
   localparam logic [COIN_VAL_W-1:0] VAL_10 = 8'd10;
   localparam logic [COIN_VAL_W-1:0] VAL_5  = 8'd5;
   localparam logic [COIN_VAL_W-1:0] VAL_1  = 8'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SELECT,
      ST_EJECT,
      ST_DONE
   } state_e;

   function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [3:0] coin);
      case (coin)
         COIN_25: return VAL_25;
         COIN_10: return VAL_10;
         COIN_5:  return VAL_5;
         COIN_1:  return VAL_1;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/vm_coin_select.sv
// Greedy coin picker: largest coin that fits the remaining amount and whose
// hopper is neither empty nor marked faulty.
module vm_coin_select
   import vm_change_pkg::*;
#(
   parameter int AMOUNT_W = 8
) (
   input  logic [AMOUNT_W-1:0] remaining,
   input  logic [3:0]          hop_empty,
   input  logic [3:0]          fault_mask,
   output logic [3:0]          coin,
   output logic                found
);

   logic [3:0] usable;

   assign usable = ~hop_empty & ~fault_mask;

   always_comb begin
      coin = '0;
      if (usable[3] && remaining >= AMOUNT_W'(VAL_25))
         coin = COIN_25;
      else if (usable[2] && remaining >= AMOUNT_W'(VAL_10))
         coin = COIN_10;
      else if (usable[1] && remaining >= AMOUNT_W'(VAL_5))
         coin = COIN_5;
      else if (usable[0] && remaining >= AMOUNT_W'(VAL_1))
         coin = COIN_1;
   end

   assign found = |coin;

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays a requested amount coin by coin through the hoppers,
// masking any hopper that fails to acknowledge within ACK_TIMEOUT cycles.
module vm_change_dispenser
   import vm_change_pkg::*;
#(
   parameter int AMOUNT_W    = 8,
   parameter int ACK_TIMEOUT = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic [AMOUNT_W-1:0] req_amount,
   output logic                req_ready,
   input  logic [3:0]          hop_empty,
   output logic [3:0]          hop_eject,
   input  logic                hop_ack,
   output logic                busy,
   output logic                done,
   output logic                done_err,
   output logic [AMOUNT_W-1:0] remaining
);

   localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_e           state;
   logic [3:0]       fault_mask;
   logic [CNT_W-1:0] ack_cnt;
   logic [3:0]       sel_coin;
   logic             sel_found;

   vm_coin_select #(
      .AMOUNT_W (AMOUNT_W)
   ) u_select (
      .remaining  (remaining),
      .hop_empty  (hop_empty),
      .fault_mask (fault_mask),
      .coin       (sel_coin),
      .found      (sel_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         hop_eject  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_err   <= 1'b0;
         remaining  <= '0;
         fault_mask <= '0;
         ack_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  remaining  <= req_amount;
                  fault_mask <= '0;
                  req_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_SELECT;
               end
            end

            ST_SELECT: begin
               ack_cnt <= '0;
               if (sel_found) begin
                  hop_eject <= sel_coin;
                  state     <= ST_EJECT;
               end else begin
                  // Either fully paid or no usable coin is left for the rest.
                  done     <= 1'b1;
                  done_err <= (remaining != '0);
                  state    <= ST_DONE;
               end
            end

            ST_EJECT: begin
               if (hop_ack) begin
                  remaining <= remaining - AMOUNT_W'(coin_value(hop_eject));
                  hop_eject <= '0;
                  ack_cnt   <= '0;
                  state     <= ST_SELECT;
               end else if (ack_cnt == CNT_LAST) begin
                  fault_mask <= fault_mask | hop_eject;
                  hop_eject  <= '0;
                  ack_cnt    <= '0;
                  state      <= ST_SELECT;
               end else begin
                  ack_cnt <= ack_cnt + CNT_W'(1);
               end
            end

            ST_DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser with a simple hopper responder.
module tb_vm_change_dispenser;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [7:0] req_amount;
   logic       req_ready;
   logic [3:0] hop_empty;
   logic [3:0] hop_eject;
   logic       hop_ack;
   logic       busy;
   logic       done;
   logic       done_err;
   logic [7:0] remaining;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] r_seq;
   int          r_ncoins, r_done_idx, r_first_ej, r_max_run;
   logic        r_done_seen, r_err, r_busy1;
   logic [7:0]  r_rem;
   logic        r_done_after, r_busy_after, r_ready_after;

   vm_change_dispenser #(
      .AMOUNT_W    (8),
      .ACK_TIMEOUT (200)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_amount (req_amount),
      .req_ready  (req_ready),
      .hop_empty  (hop_empty),
      .hop_eject  (hop_eject),
      .hop_ack    (hop_ack),
      .busy       (busy),
      .done       (done),
      .done_err   (done_err),
      .remaining  (remaining)
   );

   always #5 clk = ~clk;

   function automatic int cval(input logic [3:0] e);
      case (e)
         4'b1000: return 25;
         4'b0100: return 10;
         4'b0010: return 5;
         4'b0001: return 1;
         default: return 0;
      endcase
   endfunction

   // Issues one request and plays the hoppers: ack on the first cycle an eject
   // is seen, except for hoppers listed in stuck. Cycle index 1 is the cycle
   // right after the accepting edge.
   task automatic run_txn(input logic [7:0] amt, input logic [3:0] empty, input logic [3:0] stuck);
      int         run;
      logic [3:0] prev;
      r_seq = '0; r_ncoins = 0; r_done_seen = 1'b0; r_err = 1'b0; r_rem = '0;
      r_done_idx = -1; r_first_ej = -1; r_max_run = 0; r_busy1 = 1'b0;
      run = 0; prev = '0;
      @(negedge clk);
      hop_empty = empty; req_amount = amt; req_valid = 1'b1; hop_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 1; i <= 600 && !r_done_seen; i++) begin
         if (i > 1) @(negedge clk);
         hop_ack = 1'b0;
         if (i == 1) r_busy1 = busy;
         if (hop_eject != '0) begin
            if (prev == '0) begin
               r_seq = (r_seq << 8) | 64'(cval(hop_eject));
               r_ncoins++;
               if (r_first_ej < 0) r_first_ej = i;
            end
            run++;
            if (run > r_max_run) r_max_run = run;
            if ((hop_eject & stuck) == '0) hop_ack = 1'b1;
         end else begin
            run = 0;
         end
         prev = hop_eject;
         if (done) begin
            r_done_seen = 1'b1; r_err = done_err; r_rem = remaining; r_done_idx = i;
         end
      end
      @(negedge clk);
      hop_ack = 1'b0;
      r_done_after = done; r_busy_after = busy; r_ready_after = req_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_amount = '0; hop_empty = '0; hop_ack = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", req_ready); end
      n_checks++; if (hop_eject !== 4'b0) begin n_fail++; $display("FAIL reset_eject: got %b expected 0000", hop_eject); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || done_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%0b done=%0b err=%0b expected 0", busy, done, done_err); end
      n_checks++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_greedy_72();
      run_txn(8'd72, 4'b0000, 4'b0000);
      n_checks++; if (r_busy1 !== 1'b1) begin n_fail++; $display("FAIL g72_busy: got %0b expected 1", r_busy1); end
      n_checks++; if (r_first_ej !== 2) begin n_fail++; $display("FAIL g72_first_eject_cycle: got %0d expected 2", r_first_ej); end
      n_checks++; if (r_ncoins !== 6 || r_seq !== {16'd0, 8'd25, 8'd25, 8'd10, 8'd10, 8'd1, 8'd1}) begin n_fail++; $display("FAIL g72_coins: got n=%0d seq=%h expected n=6 seq=000019190a0a0101", r_ncoins, r_seq); end
      n_checks++; if (r_done_seen !== 1'b1 || r_err !== 1'b0 || r_rem !== 8'd0) begin n_fail++; $display("FAIL g72_done: got seen=%0b err=%0b rem=%0d expected 1 0 0", r_done_seen, r_err, r_rem); end
      n_checks++; if (r_done_idx !== 14) begin n_fail++; $display("FAIL g72_done_cycle: got %0d expected 14", r_done_idx); end
      n_checks++; if (r_done_after !== 1'b0 || r_busy_after !== 1'b0 || r_ready_after !== 1'b1) begin n_fail++; $display("FAIL g72_after: got done=%0b busy=%0b ready=%0b expected 0 0 1", r_done_after, r_busy_after, r_ready_after); end
      n_checks++; if (done_err !== 1'b0 || remaining !== 8'd0) begin n_fail++; $display("FAIL g72_hold: got err=%0b rem=%0d expected 0 0", done_err, remaining); end
   endtask

   task automatic test_no_quarter();
      run_txn(8'd30, 4'b1000, 4'b0000);
      n_checks++; if (r_ncoins !== 3 || r_seq !== 64'h0a0a0a) begin n_fail++; $display("FAIL nq30_coins: got n=%0d seq=%h expected n=3 seq=0a0a0a", r_ncoins, r_seq); end
      n_checks++; if (r_done_seen !== 1'b1 || r_err !== 1'b0 || r_rem !== 8'd0 || r_done_idx !== 8) begin n_fail++; $display("FAIL nq30_done: got seen=%0b err=%0b rem=%0d cyc=%0d expected 1 0 0 8", r_done_seen, r_err, r_rem, r_done_idx); end
   endtask

   task automatic test_short_change();
      run_txn(8'd7, 4'b0001, 4'b0000);
      n_checks++; if (r_ncoins !== 1 || r_seq !== 64'h05) begin n_fail++; $display("FAIL short7_coins: got n=%0d seq=%h expected n=1 seq=05", r_ncoins, r_seq); end
      n_checks++; if (r_done_seen !== 1'b1 || r_err !== 1'b1 || r_rem !== 8'd2 || r_done_idx !== 4) begin n_fail++; $display("FAIL short7_done: got seen=%0b err=%0b rem=%0d cyc=%0d expected 1 1 2 4", r_done_seen, r_err, r_rem, r_done_idx); end
      n_checks++; if (done_err !== 1'b1 || remaining !== 8'd2) begin n_fail++; $display("FAIL short7_hold: got err=%0b rem=%0d expected 1 2", done_err, remaining); end
   endtask

   task automatic test_timeout();
      run_txn(8'd25, 4'b0000, 4'b1000);
      n_checks++; if (r_max_run !== 200) begin n_fail++; $display("FAIL to25_eject_len: got %0d expected 200", r_max_run); end
      n_checks++; if (r_ncoins !== 4 || r_seq !== 64'h190a0a05) begin n_fail++; $display("FAIL to25_coins: got n=%0d seq=%h expected n=4 seq=190a0a05", r_ncoins, r_seq); end
      n_checks++; if (r_done_seen !== 1'b1 || r_err !== 1'b0 || r_rem !== 8'd0 || r_done_idx !== 209) begin n_fail++; $display("FAIL to25_done: got seen=%0b err=%0b rem=%0d cyc=%0d expected 1 0 0 209", r_done_seen, r_err, r_rem, r_done_idx); end
   endtask

   task automatic test_zero_and_busy_req();
      logic ej_seen;
      ej_seen = 1'b0;
      @(negedge clk);
      hop_empty = '0; req_amount = 8'd0; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_amount = 8'd9;
      if (hop_eject != '0) ej_seen = 1'b1;
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_cycle1: got busy=%0b done=%0b expected 1 0", busy, done); end
      @(negedge clk);
      req_valid = 1'b0;
      if (hop_eject != '0) ej_seen = 1'b1;
      n_checks++; if (done !== 1'b1 || done_err !== 1'b0 || remaining !== 8'd0) begin n_fail++; $display("FAIL zero_done: got done=%0b err=%0b rem=%0d expected 1 0 0", done, done_err, remaining); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (hop_eject != '0) ej_seen = 1'b1;
      end
      n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || remaining !== 8'd0) begin n_fail++; $display("FAIL zero_second_req_ignored: got busy=%0b ready=%0b rem=%0d expected 0 1 0", busy, req_ready, remaining); end
      n_checks++; if (ej_seen !== 1'b0) begin n_fail++; $display("FAIL zero_no_eject: got %0b expected 0", ej_seen); end
   endtask

   task automatic test_reset_abort();
      logic done_seen;
      done_seen = 1'b0;
      @(negedge clk);
      hop_empty = '0; req_amount = 8'd40; req_valid = 1'b1; hop_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (hop_eject !== 4'b1000) begin n_fail++; $display("FAIL abort_eject_before: got %b expected 1000", hop_eject); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (hop_eject !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_async_drop: got eject=%b busy=%0b expected 0000 0", hop_eject, busy); end
      @(negedge clk);
      if (done) done_seen = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      n_checks++; if (req_ready !== 1'b1 || done_seen !== 1'b0) begin n_fail++; $display("FAIL abort_after_release: got ready=%0b done_seen=%0b expected 1 0", req_ready, done_seen); end
      run_txn(8'd5, 4'b0000, 4'b0000);
      n_checks++; if (r_ncoins !== 1 || r_seq !== 64'h05 || r_done_seen !== 1'b1 || r_err !== 1'b0 || r_rem !== 8'd0) begin n_fail++; $display("FAIL abort_next_txn: got n=%0d seq=%h seen=%0b err=%0b rem=%0d expected 1 05 1 0 0", r_ncoins, r_seq, r_done_seen, r_err, r_rem); end
   endtask

   initial begin
      test_reset();
      test_greedy_72();
      test_no_quarter();
      test_short_change();
      test_timeout();
      test_zero_and_busy_req();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
